audio_frame_sequencer: RTL and testbench

//  Streams a run of audio frames through AudioProcessor without host babysitting. Per frame:
//  - load BEATS beats from a valid/ready input stream into the processor's input buffer;
//  - pulse start and wait for done;
//  - drain BEATS result beats to a valid/ready output stream.
//  It sits between the host DMA and AudioProcessor, replacing per-beat host writes. It adds

---
 rtl/audio_frame_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_audio_frame_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_sequencer.sv
// Frame sequencer for AudioProcessor: loads a frame from an input stream, starts the processor,
// waits for done (with timeout), then drains the results to an output stream.
module audio_frame_sequencer #(
    parameter int BUS_W       = 512,
    parameter int BEATS       = 64,
    parameter int FRAMES_W    = 16,
    parameter int TIMEOUT_CYC = 1 << 20,
    localparam int IDX_W      = $clog2(BEATS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                abort,
    input  logic [FRAMES_W-1:0] cfg_frames,
    output logic                busy,
    output logic [FRAMES_W-1:0] frames_done,
    output logic                err_timeout,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_W-1:0]    in_data,
    output logic                proc_wr_en,
    output logic [IDX_W-1:0]    proc_in_idx,
    output logic [BUS_W-1:0]    proc_data_in,
    output logic                proc_start,
    input  logic                proc_done,
    output logic [IDX_W-1:0]    proc_out_idx,
    input  logic [BUS_W-1:0]    proc_data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUS_W-1:0]    out_data,
    output logic                out_last
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [FRAMES_W-1:0] frames_left_q, frames_left_d;
    logic [FRAMES_W-1:0] frames_done_q, frames_done_d;
    logic                err_q, err_d;
    logic                zero_pulse_q, zero_pulse_d;
    logic [IDX_W-1:0]    beat_q, beat_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                done_q, done_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                pending_q, pending_d;
    logic                fetched_q, fetched_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [BUS_W-1:0]    out_data_q, out_data_d;

    logic in_xfer, out_xfer;

    assign in_xfer  = (state_q == S_LOAD) && in_valid;
    assign out_xfer = out_valid_q && out_ready;

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        frames_done_d = frames_done_q;
        err_d         = err_q;
        zero_pulse_d  = 1'b0;
        beat_d        = beat_q;
        to_cnt_d      = to_cnt_q;
        done_d        = done_q;
        rd_idx_d      = rd_idx_q;
        pending_d     = 1'b0;
        fetched_d     = fetched_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_data_d    = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (go && !abort) begin
                    frames_done_d = '0;
                    err_d         = 1'b0;
                    if (cfg_frames != '0) begin
                        frames_left_d = cfg_frames;
                        state_d       = S_LOAD;
                    end else begin
                        zero_pulse_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    if (beat_q == LAST_IDX) begin
                        beat_d  = '0;
                        state_d = S_START;
                    end else begin
                        beat_d = beat_q + IDX_W'(1);
                    end
                end
            end
            S_START: begin
                // Seed the edge detector with the current level so a stale done is not an edge.
                to_cnt_d = '0;
                done_d   = proc_done;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                done_d   = proc_done;
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (proc_done && !done_q) begin
                    state_d = S_DRAIN;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // An index presented now is captured next cycle, so only issue when the slot frees.
                pending_d = !pending_q && !fetched_q && (!out_valid_q || out_xfer);
                if (pending_q) begin
                    out_data_d  = proc_data_out;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_idx_q == LAST_IDX);
                    fetched_d   = (rd_idx_q == LAST_IDX);
                    rd_idx_d    = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
                end
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d    = 1'b0;
                        fetched_d     = 1'b0;
                        frames_left_d = frames_left_q - FRAMES_W'(1);
                        if (frames_done_q != '1) frames_done_d = frames_done_q + FRAMES_W'(1);
                        state_d = (frames_left_q == FRAMES_W'(1)) ? S_IDLE : S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            beat_d      = '0;
            rd_idx_d    = '0;
            pending_d   = 1'b0;
            fetched_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            frames_left_q <= '0;
            frames_done_q <= '0;
            err_q         <= 1'b0;
            zero_pulse_q  <= 1'b0;
            beat_q        <= '0;
            to_cnt_q      <= '0;
            done_q        <= 1'b0;
            rd_idx_q      <= '0;
            pending_q     <= 1'b0;
            fetched_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            frames_done_q <= frames_done_d;
            err_q         <= err_d;
            zero_pulse_q  <= zero_pulse_d;
            beat_q        <= beat_d;
            to_cnt_q      <= to_cnt_d;
            done_q        <= done_d;
            rd_idx_q      <= rd_idx_d;
            pending_q     <= pending_d;
            fetched_q     <= fetched_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
        end
    end

    assign busy         = (state_q != S_IDLE) || zero_pulse_q;
    assign frames_done  = frames_done_q;
    assign err_timeout  = err_q;
    assign in_ready     = (state_q == S_LOAD);
    assign proc_wr_en   = in_xfer;
    assign proc_in_idx  = beat_q;
    assign proc_data_in = (state_q == S_LOAD) ? in_data : '0;
    assign proc_start   = (state_q == S_START);
    assign proc_out_idx = rd_idx_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Bench for audio_frame_sequencer: behavioural AudioProcessor, stream scoreboard, run table and
// hand-written corner sequences (timeout, abort, zero-frame go, reset during drain).
module tb_audio_frame_sequencer;

    localparam int BUS_W    = 64;
    localparam int BEATS    = 64;
    localparam int FRAMES_W = 16;
    localparam int TO_CYC   = 100;
    localparam int IDX_W    = $clog2(BEATS);
    localparam logic [63:0] MASK = 64'h5A5A_C3C3_0F0F_9696;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                go = 1'b0;
    logic                abort = 1'b0;
    logic [FRAMES_W-1:0] cfg_frames = '0;
    logic                busy, err_timeout, in_ready, proc_wr_en, proc_start, out_valid, out_last;
    logic [FRAMES_W-1:0] frames_done;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [BUS_W-1:0]    in_data = '0;
    logic [IDX_W-1:0]    proc_in_idx, proc_out_idx;
    logic [BUS_W-1:0]    proc_data_in, out_data;
    logic                proc_done = 1'b0;
    logic [BUS_W-1:0]    proc_data_out = '0;

    audio_frame_sequencer #(
        .BUS_W(BUS_W), .BEATS(BEATS), .FRAMES_W(FRAMES_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .cfg_frames(cfg_frames),
        .busy(busy), .frames_done(frames_done), .err_timeout(err_timeout),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .proc_wr_en(proc_wr_en), .proc_in_idx(proc_in_idx), .proc_data_in(proc_data_in),
        .proc_start(proc_start), .proc_done(proc_done), .proc_out_idx(proc_out_idx),
        .proc_data_out(proc_data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus modes: vmode 0=idle 1=always 2=random; rmode 0=never 1=always 2=1-0-0-1 3=random.
    int vmode = 0;
    int rmode = 0;
    int lat   = 10;
    int cyc   = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        case (vmode)
            0:       in_valid = 1'b0;
            1:       in_valid = 1'b1;
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = {$urandom, $urandom};
        case (rmode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // AudioProcessor model: result[i] = input[i] ^ MASK, done rises lat cycles after start
    // (lat 0: never), read data registered one cycle after the index.
    logic [BUS_W-1:0] pmem [BEATS];
    int               p_cnt = 0;

    always @(posedge clk) begin
        if (proc_wr_en) pmem[proc_in_idx] <= proc_data_in;
        proc_data_out <= pmem[proc_out_idx] ^ MASK;
        if (proc_start) begin
            proc_done <= 1'b0;
            p_cnt     <= lat;
        end else if (p_cnt != 0) begin
            p_cnt <= p_cnt - 1;
            if (p_cnt == 1) proc_done <= 1'b1;
        end
    end

    // Stream scoreboard: every drained beat must be the next loaded beat ^ MASK, in order.
    logic [BUS_W-1:0] exp_q [$];
    int               wr_idx = 0, out_idx = 0;
    int               n_wr = 0, n_start = 0, n_out = 0, n_last = 0;
    logic             prev_stall = 1'b0, prev_abort = 1'b0;
    logic [BUS_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
            end
            check("wr_en_handshake", 64'(proc_wr_en), 64'(in_valid & in_ready));
            if (in_valid && in_ready) begin
                check("in_idx", 64'(proc_in_idx), 64'(wr_idx));
                check("data_in", 64'(proc_data_in), 64'(in_data));
                exp_q.push_back(in_data ^ MASK);
                wr_idx = (wr_idx + 1) % BEATS;
                n_wr++;
            end
            if (proc_start) n_start++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_underflow", 64'd1, 64'd0);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
                check("out_last", 64'(out_last), 64'(out_idx == BEATS - 1));
                out_idx = (out_idx + 1) % BEATS;
                n_out++;
                if (out_last) n_last++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_abort = abort;
            prev_data  = out_data;
            if (!busy) begin
                exp_q.delete();
                wr_idx  = 0;
                out_idx = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int frames;
        int vmode;
        int rmode;
        int lat;
        int exp_frames_done;
        int exp_starts;
        int exp_wr;
        int exp_out;
        int exp_last;
    } vec_t;

    task automatic pulse_go(input int frames, input logic with_abort);
        @(posedge clk); #1;
        go         = 1'b1;
        abort      = with_abort;
        cfg_frames = FRAMES_W'(frames);
        @(posedge clk); #1;
        go    = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int s_start, s_wr, s_out, s_last;
        vmode = v.vmode;
        rmode = v.rmode;
        lat   = v.lat;
        s_start = n_start; s_wr = n_wr; s_out = n_out; s_last = n_last;
        pulse_go(v.frames, 1'b0);
        check("busy_after_go", 64'(busy), 64'd1);
        check("err_cleared_by_go", 64'(err_timeout), 64'd0);
        check("frames_done_cleared", 64'(frames_done), 64'd0);
        wait_idle(30000);
        check("run_frames_done", 64'(frames_done), 64'(v.exp_frames_done));
        check("run_starts", 64'(n_start - s_start), 64'(v.exp_starts));
        check("run_wr_beats", 64'(n_wr - s_wr), 64'(v.exp_wr));
        check("run_out_beats", 64'(n_out - s_out), 64'(v.exp_out));
        check("run_last_beats", 64'(n_last - s_last), 64'(v.exp_last));
        check("run_err", 64'(err_timeout), 64'd0);
    endtask

    vec_t vecs [4];
    vec_t tmp;
    int   s0;

    initial begin
        vecs[0] = '{frames: 3, vmode: 1, rmode: 1, lat: 10, exp_frames_done: 3,
                    exp_starts: 3, exp_wr: 192, exp_out: 192, exp_last: 3};
        vecs[1] = '{frames: 2, vmode: 1, rmode: 2, lat: 5, exp_frames_done: 2,
                    exp_starts: 2, exp_wr: 128, exp_out: 128, exp_last: 2};
        vecs[2] = '{frames: 2, vmode: 2, rmode: 3, lat: 3, exp_frames_done: 2,
                    exp_starts: 2, exp_wr: 128, exp_out: 128, exp_last: 2};
        vecs[3] = '{frames: 1, vmode: 2, rmode: 1, lat: 1, exp_frames_done: 1,
                    exp_starts: 1, exp_wr: 64, exp_out: 64, exp_last: 1};

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_frames_done", 64'(frames_done), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Done never rises: timeout fires at the end of the 100th WAIT cycle.
        vmode = 1; rmode = 1; lat = 0;
        pulse_go(1, 1'b0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (proc_start) break;
        end
        check("to_start_seen", 64'(proc_start), 64'd1);
        repeat (TO_CYC) @(negedge clk);
        check("to_err_before", 64'(err_timeout), 64'd0);
        check("to_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        check("to_err_set", 64'(err_timeout), 64'd1);
        check("to_busy_clear", 64'(busy), 64'd0);
        check("to_frames_done", 64'(frames_done), 64'd0);

        // Next accepted go clears the sticky error (checked right after go inside run_vec).
        tmp = '{frames: 1, vmode: 1, rmode: 3, lat: 4, exp_frames_done: 1,
                exp_starts: 1, exp_wr: 64, exp_out: 64, exp_last: 1};
        run_vec(tmp);

        // Zero-frame go: one-cycle busy, no start, frames_done cleared.
        s0 = n_start;
        pulse_go(0, 1'b0);
        check("zero_busy_pulse", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("zero_busy_end", 64'(busy), 64'd0);
        check("zero_frames_done", 64'(frames_done), 64'd0);
        repeat (3) @(posedge clk);
        check("zero_no_start", 64'(n_start - s0), 64'd0);

        // Abort at LOAD beat 30 of frame 2.
        vmode = 1; rmode = 1; lat = 3;
        pulse_go(4, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (proc_wr_en && proc_in_idx == IDX_W'(29) && frames_done == FRAMES_W'(1)) break;
        end
        check("abort_reach_beat29", 64'(proc_in_idx), 64'd29);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_frames_done", 64'(frames_done), 64'd1);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_wr_en_low", 64'(proc_wr_en), 64'd0);
        end

        // go with abort in IDLE: abort wins, frames_done not cleared.
        pulse_go(2, 1'b1);
        check("go_abort_busy", 64'(busy), 64'd0);
        check("go_abort_frames_done", 64'(frames_done), 64'd1);

        // Reset asserted while out_valid is held by a stalled sink.
        vmode = 1; rmode = 0; lat = 2;
        pulse_go(1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("drain_valid_before_rst", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_out_data", 64'(out_data), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_out_idx", 64'(proc_out_idx), 64'd0);
        check("rst_mid_out_last", 64'(out_last), 64'd0);
        check("rst_mid_data_in", 64'(proc_data_in), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        vmode = 0; rmode = 1;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
